seq_calc: RTL and testbench
===========================

// Module: seq_calc
// PURPOSE
//  Parametrised, clocked successor to the 4-op combinational calculator (add/sub/mul/div).
//  Takes signed operands over a valid/ready handshake. Computes MUL and DIV iteratively
//  over W cycles, and ADD/SUB in one cycle. Returns a signed result plus a divide-by-zero flag.
//  Sits between an operand source (e.g. a keypad/UART decoder) and a display/result sink.
// PARAMETERS
//  W   5    operand width, signed two's complement; legal range 2..32
//  RW  2*W  result width; 2*W holds every result, including (-2^(W-1))*(-2^(W-1)) and MIN/-1
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand bundle valid
//  in_ready   out  1   block can accept; high only in IDLE
//  a          in   W   signed operand A
//  b          in   W   signed operand B
//  op         in   2   00 ADD, 01 SUB, 10 MUL, 11 DIV
//  out_valid  out  1   result valid
//  out_ready  in   1   sink accepts the result
//  result     out  RW  signed result, sign-extended
//  dbz        out  1   DIV with b==0; qualified by out_valid
//  busy       out  1   state is MUL or DIV
//  rem        out  W   signed remainder (only with CALC_REM_EN)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; in_ready=1 after release; out_valid=0.
//   result=0, dbz=0, busy=0, rem=0. All internal registers cleared; an in-flight op is discarded.
//  FSM states: IDLE, MUL, DIV, DONE.
//   IDLE --accept, op ADD/SUB--> DONE; result = sext(a)+/-sext(b), registered.
//   IDLE --accept, MUL--> MUL; IDLE --accept, DIV, b!=0--> DIV.
//   IDLE --accept, DIV, b==0--> DONE with result=0, dbz=1, rem=0.
//   MUL/DIV: step counter 0..W-1; after step W-1 --> DONE.
//   DONE --out_ready--> IDLE.
//  Accept = in_valid & in_ready. Operands and op are latched on accept; inputs are ignored otherwise.
//  Latency, counted from the accept edge to out_valid high:
//   ADD/SUB/DIV-by-0: 1 cycle. MUL/DIV: W+1 cycles.
//  Throughput: at most one op per 2 cycles. in_ready is low from DONE until the handshake.
//   IDLE re-asserts in_ready on the cycle after out_valid & out_ready.
//  Backpressure: while out_valid & !out_ready, result/dbz/rem are held bit-stable.
//  MUL: shift-add on |a|,|b|, one partial-product bit per cycle.
//   Product is negated when sign(a)^sign(b).
//  DIV: restoring division on |a|,|b|, one quotient bit per cycle.
//   Quotient truncates toward zero. Remainder takes the sign of a, with |rem|<|b|.
//   MIN/-1 = +2^(W-1) is exact in RW bits; no overflow case exists.
//  Flags: dbz=0 for every op except DIV by 0. busy is high exactly in MUL/DIV.
// CONFIGURATION
//  CALC_REM_EN defined: rem port present.
//   DIV gives the signed remainder; ADD/SUB/MUL give rem=0.
//  CALC_REM_EN undefined: rem port absent; the divider's remainder register is still internal.
//   All other timing is identical.
// STRUCTURE
//  calc_pkg: op codes OP_ADD/OP_SUB/OP_MUL/OP_DIV (2-bit), state enum calc_state_t.
//  calc_pkg also holds the abs/negate helper function.
//  Sub-module calc_div_iter: W-step restoring divider on unsigned magnitudes.
//   Handshake start/done; outputs quotient and remainder.
//  The multiplier iteration, sign fix-up and FSM stay in seq_calc.
// TESTING (W=5)
//  a=8, b=7, ADD -> result=15, dbz=0, out_valid exactly 1 cycle after accept.
//  a=-8, b=-4, SUB -> result=-4.
//  a=-6, b=2, MUL -> result=-12, out_valid 6 cycles after accept, busy high for 5 cycles.
//  a=-16, b=-16, MUL -> result=256.
//  a=-7, b=2, DIV -> result=-3, rem=-1; a=-16, b=-1, DIV -> result=16, rem=0.
//  a=7, b=0, DIV -> result=0, dbz=1, latency 1.
//   Then hold out_ready=0 for 4 cycles -> outputs stable, in_ready=0.
//  Reset pulse mid-MUL (cycle 3) -> all outputs 0 at once.
//   Next ADD 1+1 -> result=2, with no residue from the aborted op.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and helpers for the sequential calculator: op codes, FSM states,
// magnitude and conditional-negate functions.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } calc_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } calc_state_t;

    // |x| for a sign-extended 32-bit value; the most negative value maps to 2^31 unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] x);
        return x[31] ? 32'(-x) : x;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] x, input logic neg);
        return neg ? 64'(-x) : x;
    endfunction

endpackage

// File: rtl/seq_calc_if.sv
// Operand/result handshake bundle for seq_calc; the rem signal exists only when
// CALC_REM_EN is defined.
interface seq_calc_if #(
    parameter int unsigned W  = 5,
    parameter int unsigned RW = 2 * W
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          dbz;
    logic          busy;
`ifdef CALC_REM_EN
    logic [W-1:0]  rem;
`endif

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, dbz, busy
`ifdef CALC_REM_EN
        , input rem
`endif
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, dbz, busy
`ifdef CALC_REM_EN
        , output rem
`endif
    );

endinterface

// File: rtl/calc_div_iter.sv
// W-step restoring divider on unsigned magnitudes; one quotient bit per cycle.
// done_c/quo_c/rem_c are combinational and valid on the final step's cycle.
module calc_div_iter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         done_c,
    output logic [W-1:0] quo_c,
    output logic [W-1:0] rem_c
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  part_q;
    logic [W-1:0]  dvs_q;

    logic [W:0]    shifted;
    logic          ge;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {part_q, quo_q[W-1]};
        ge      = shifted >= {1'b0, dvs_q};
        rem_c   = ge ? W'(shifted - {1'b0, dvs_q}) : W'(shifted);
        quo_c   = {quo_q[W-2:0], ge};
        done_c  = busy_q && (cnt_q == CW'(W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            part_q <= '0;
            dvs_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            quo_q  <= dividend_i;
            part_q <= '0;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            quo_q  <= quo_c;
            part_q <= rem_c;
            cnt_q  <= cnt_q + CW'(1);
            if (done_c) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_calc.sv
// Sequential signed calculator: single-cycle ADD/SUB, W-cycle shift-add MUL and
// restoring DIV over a valid/ready handshake. Define CALC_REM_EN for the rem output.
module seq_calc
    import calc_pkg::*;
#(
    parameter int unsigned W  = 5,
    parameter int unsigned RW = 2 * W
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_calc_if.slave bus_io
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    calc_state_t   state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic          rem_neg_q, rem_neg_d;
    logic [RW-1:0] mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [RW-1:0] result_q, result_d;
    logic          dbz_q, dbz_d;
    logic [W-1:0]  rem_q, rem_d;

    logic          accept_c;
    calc_op_t      op_c;
    logic          b_zero_c;
    logic          mul_last_c;
    logic [W-1:0]  mag_a_c, mag_b_c;
    logic [RW-1:0] acc_step_c;
    logic          div_start_c, div_done_c;
    logic [W-1:0]  div_quo_c, div_rem_c;

    assign accept_c    = bus_io.in_valid && in_ready_q;
    assign op_c        = calc_op_t'(bus_io.op);
    assign b_zero_c    = (bus_io.b == '0);
    assign mul_last_c  = (cnt_q == CW'(W - 1));
    assign mag_a_c     = W'(mag32(32'(signed'(bus_io.a))));
    assign mag_b_c     = W'(mag32(32'(signed'(bus_io.b))));
    assign acc_step_c  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign div_start_c = accept_c && (op_c == OP_DIV) && !b_zero_c;

    calc_div_iter #(.W(W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start_c),
        .dividend_i (mag_a_c),
        .divisor_i  (mag_b_c),
        .done_c     (div_done_c),
        .quo_c      (div_quo_c),
        .rem_c      (div_rem_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    unique case (op_c)
                        OP_MUL:  state_d = ST_MUL;
                        OP_DIV:  state_d = b_zero_c ? ST_DONE : ST_DIV;
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_MUL:  if (mul_last_c) state_d = ST_DONE;
            ST_DIV:  if (div_done_c) state_d = ST_DONE;
            ST_DONE: if (bus_io.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it.
    always_comb begin
        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_MUL) || (state_d == ST_DIV);
    end

    always_comb begin
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        result_d  = result_q;
        dbz_d     = dbz_q;
        rem_d     = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    cnt_d     = '0;
                    neg_d     = bus_io.a[W-1] ^ bus_io.b[W-1];
                    rem_neg_d = bus_io.a[W-1];
                    mcand_d   = RW'(mag_a_c);
                    mplier_d  = mag_b_c;
                    acc_d     = '0;
                    dbz_d     = 1'b0;
                    rem_d     = '0;
                    unique case (op_c)
                        OP_ADD: result_d = {{(RW-W){bus_io.a[W-1]}}, bus_io.a}
                                         + {{(RW-W){bus_io.b[W-1]}}, bus_io.b};
                        OP_SUB: result_d = {{(RW-W){bus_io.a[W-1]}}, bus_io.a}
                                         - {{(RW-W){bus_io.b[W-1]}}, bus_io.b};
                        OP_DIV: begin
                            if (b_zero_c) begin
                                result_d = '0;
                                dbz_d    = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                acc_d    = acc_step_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (mul_last_c) result_d = RW'(cond_neg64(64'(acc_step_c), neg_q));
            end
            ST_DIV: begin
                if (div_done_c) begin
                    result_d = RW'(cond_neg64(64'(div_quo_c), neg_q));
                    rem_d    = W'(cond_neg64(64'(div_rem_c), rem_neg_q));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
            rem_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
            rem_q     <= rem_d;
        end
    end

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.result    = result_q;
    assign bus_io.dbz       = dbz_q;
    assign bus_io.busy      = busy_q;
`ifdef CALC_REM_EN
    assign bus_io.rem       = rem_q;
`else
    // Remainder path is kept internally but has no port in this build.
    logic unused_rem;
    assign unused_rem = ^rem_q;
`endif

endmodule

// File: tb/tb_seq_calc.sv
// Directed self-checking bench for seq_calc at W=5 (rem checked when CALC_REM_EN is defined).
module tb_seq_calc;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_calc_if #(.W(5), .RW(10)) bus ();

    seq_calc #(.W(5), .RW(10)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure latency and busy cycles, optionally stall the sink, then complete.
    task automatic run_op(input string tag, input logic [4:0] ta, input logic [4:0] tbv,
                          input logic [1:0] top, input int er, input logic ed, input int erem,
                          input int elat, input int ebusy, input int hold);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tbv;
        bus.op       = top;
        cyc();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.busy) bcnt++;
            cyc();
            lat++;
        end
        chk({tag, ".lat"},      lat, elat);
        chk({tag, ".busy_cyc"}, bcnt, ebusy);
        chk({tag, ".result"},   $signed(bus.result), er);
        chk({tag, ".dbz"},      bus.dbz, ed);
`ifdef CALC_REM_EN
        chk({tag, ".rem"},      $signed(bus.rem), erem);
`else
        if (erem != erem) $display("unreachable");
`endif
        chk({tag, ".in_ready"}, bus.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 5'd3;
            bus.b        = 5'd3;
            bus.op       = OP_ADD;
            cyc();
            chk({tag, ".hold_result"},    $signed(bus.result), er);
            chk({tag, ".hold_dbz"},       bus.dbz, ed);
            chk({tag, ".hold_out_valid"}, bus.out_valid, 1);
            chk({tag, ".hold_in_ready"},  bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk({tag, ".post_out_valid"}, bus.out_valid, 0);
        chk({tag, ".post_in_ready"},  bus.in_ready, 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_ADD;
        cyc();
        cyc();
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.result",    $signed(bus.result), 0);
        chk("rst.dbz",       bus.dbz, 0);
        chk("rst.busy",      bus.busy, 0);
        rst_n = 1'b1;
        cyc();
        chk("rst.in_ready",  bus.in_ready, 1);

        run_op("add_8_7",     5'd8,      5'd7,      OP_ADD, 15,  1'b0, 0,  1, 0, 0);
        run_op("sub_m8_m4",   5'b11000,  5'b11100,  OP_SUB, -4,  1'b0, 0,  1, 0, 0);
        run_op("mul_m6_2",    5'b11010,  5'd2,      OP_MUL, -12, 1'b0, 0,  6, 5, 0);
        run_op("mul_m16_m16", 5'b10000,  5'b10000,  OP_MUL, 256, 1'b0, 0,  6, 5, 0);
        run_op("div_m7_2",    5'b11001,  5'd2,      OP_DIV, -3,  1'b0, -1, 6, 5, 0);
        run_op("div_m16_m1",  5'b10000,  5'b11111,  OP_DIV, 16,  1'b0, 0,  6, 5, 0);
        run_op("div_7_m2",    5'd7,      5'b11110,  OP_DIV, -3,  1'b0, 1,  6, 5, 0);
        run_op("div_7_0",     5'd7,      5'd0,      OP_DIV, 0,   1'b1, 0,  1, 0, 4);
        run_op("add_3_4",     5'd3,      5'd4,      OP_ADD, 7,   1'b0, 0,  1, 0, 0);

        // Abort a multiply mid-flight with an asynchronous reset.
        bus.in_valid = 1'b1;
        bus.a        = 5'd7;
        bus.b        = 5'd3;
        bus.op       = OP_MUL;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        chk("abort.busy_before", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", bus.out_valid, 0);
        chk("abort.result",    $signed(bus.result), 0);
        chk("abort.dbz",       bus.dbz, 0);
        chk("abort.busy",      bus.busy, 0);
`ifdef CALC_REM_EN
        chk("abort.rem",       $signed(bus.rem), 0);
`endif
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("abort.in_ready",  bus.in_ready, 1);
        chk("abort.out_valid_after", bus.out_valid, 0);

        run_op("add_1_1", 5'd1, 5'd1, OP_ADD, 2, 1'b0, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
